// File: rtl/capp_response_reader.sv
// CAPP response reader: snapshots tags and drains {index, word} pairs in ascending order.
// Optional match_count output when CAPP_MATCH_COUNT_EN is defined.
module capp_response_reader #(
    parameter int NUM_CELLS  = 100,
    parameter int WORD_WIDTH = 32,
    parameter int READ_LAT   = 1,
    localparam int IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_CELLS-1:0]  tag_wires,
    input  logic [WORD_WIDTH-1:0] read_lines,
    output logic [NUM_CELLS-1:0]  row_select,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_index,
    output logic [WORD_WIDTH-1:0] out_data,
`ifdef CAPP_MATCH_COUNT_EN
    output logic [IDX_W:0]        match_count,
`endif
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
    localparam logic [NUM_CELLS-1:0] ONE = NUM_CELLS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NUM_CELLS-1:0] pending;
    logic [NUM_CELLS-1:0] pend_rest;
    logic [IDX_W-1:0]     cur_idx;
    logic [IDX_W-1:0]     low_idx;
    logic [CNT_W-1:0]     cnt;
    logic                 go;
    logic                 kill;
    logic                 xfer;

    assign go   = (state == S_IDLE) && start && !abort;
    assign kill = (state != S_IDLE) && abort;
    assign xfer = (state == S_PRESENT) && out_valid && out_ready;
    assign busy = (state != S_IDLE);

    // Lowest pending index wins: scan downward so the last hit is the smallest.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign pend_rest = pending & ~(ONE << cur_idx);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt = (tag_wires == '0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (xfer) begin
                    state_nxt = (pend_rest == '0) ? S_DONE : S_SELECT;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (kill) begin
            state_nxt = S_IDLE;
        end
    end

    // The WAIT count gives the cells READ_LAT cycles after row_select is registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending    <= '0;
            cur_idx    <= '0;
            cnt        <= '0;
            row_select <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_data   <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                pending    <= '0;
                row_select <= '0;
                out_valid  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (go) begin
                            pending <= tag_wires;
                        end
                    end
                    S_SELECT: begin
                        cur_idx    <= low_idx;
                        row_select <= ONE << low_idx;
                        cnt        <= CNT_W'(READ_LAT);
                    end
                    S_WAIT: begin
                        if (cnt == '0) begin
                            out_data   <= read_lines;
                            out_index  <= cur_idx;
                            out_valid  <= 1'b1;
                            row_select <= '0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_PRESENT: begin
                        if (xfer) begin
                            out_valid <= 1'b0;
                            pending   <= pend_rest;
                        end
                    end
                    S_DONE: begin
                        done <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef CAPP_MATCH_COUNT_EN
    logic [IDX_W:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            pop = pop + (IDX_W + 1)'(tag_wires[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            match_count <= '0;
        end else if (kill) begin
            match_count <= '0;
        end else if (go) begin
            match_count <= pop;
        end
    end
`endif

endmodule

// File: tb/tb_capp_response_reader.sv
// Directed bench for capp_response_reader: two instances (READ_LAT=1 and 3)
// each with a pipelined cells model returning 0x100+row.
module tb_capp_response_reader;

    localparam int N  = 100;
    localparam int W  = 32;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic          start1 = 0, abort1 = 0, ready1 = 0;
    logic [N-1:0]  tags1 = '0, rs1;
    logic [W-1:0]  rl1 = '0, data1;
    logic [IW-1:0] idx1;
    logic          valid1, busy1, done1;

    logic          start3 = 0, abort3 = 0, ready3 = 0;
    logic [N-1:0]  tags3 = '0, rs3;
    logic [W-1:0]  rl3 = '0, data3, p3a = '0, p3b = '0;
    logic [IW-1:0] idx3;
    logic          valid3, busy3, done3;

`ifdef CAPP_MATCH_COUNT_EN
    logic [IW:0]   mc1, mc3;
`endif

    capp_response_reader #(.NUM_CELLS(N), .WORD_WIDTH(W), .READ_LAT(1)) d1 (
        .CLK(clk), .RST(rst), .start(start1), .abort(abort1),
        .tag_wires(tags1), .read_lines(rl1), .row_select(rs1),
        .out_valid(valid1), .out_ready(ready1), .out_index(idx1),
        .out_data(data1),
`ifdef CAPP_MATCH_COUNT_EN
        .match_count(mc1),
`endif
        .busy(busy1), .done(done1)
    );

    capp_response_reader #(.NUM_CELLS(N), .WORD_WIDTH(W), .READ_LAT(3)) d3 (
        .CLK(clk), .RST(rst), .start(start3), .abort(abort3),
        .tag_wires(tags3), .read_lines(rl3), .row_select(rs3),
        .out_valid(valid3), .out_ready(ready3), .out_index(idx3),
        .out_data(data3),
`ifdef CAPP_MATCH_COUNT_EN
        .match_count(mc3),
`endif
        .busy(busy3), .done(done3)
    );

    function automatic logic [W-1:0] word_of(input logic [N-1:0] rs);
        logic [W-1:0] w;
        int hits;
        w = 32'hDEAD0000;
        hits = 0;
        for (int i = 0; i < N; i++) begin
            if (rs[i]) begin
                w = 32'h100 + i;
                hits++;
            end
        end
        if (hits > 1) w = 32'hBAD00000;
        return w;
    endfunction

    always @(posedge clk) begin
        rl1 <= word_of(rs1);
        p3a <= word_of(rs3);
        p3b <= p3a;
        rl3 <= p3b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({rs1, valid1, idx1, data1, busy1, done1} !== '0) begin
            failures++;
            $display("FAIL reset_d1 got rs=%0h v=%0b i=%0d d=%0h b=%0b dn=%0b exp all 0",
                     rs1, valid1, idx1, data1, busy1, done1);
        end
        checks++;
        if ({rs3, valid3, idx3, data3, busy3, done3} !== '0) begin
            failures++;
            $display("FAIL reset_d3 got rs=%0h v=%0b i=%0d d=%0h b=%0b dn=%0b exp all 0",
                     rs3, valid3, idx3, data3, busy3, done3);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ordered(input string tag);
        tags1 = '0;
        tags1[3] = 1'b1;
        tags1[7] = 1'b1;
        ready1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tags1 = '1;
        checks++;
        if (busy1 !== 1'b1 || valid1 !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy got b=%0b v=%0b exp b=1 v=0", tag, busy1, valid1);
        end
        tick();
        checks++;
        if (rs1 !== (N'(1) << 3)) begin
            failures++;
            $display("FAIL %s_rowsel got=%0h exp=%0h", tag, rs1, N'(1) << 3);
        end
        tick();
        checks++;
        if (valid1 !== 1'b0) begin
            failures++;
            $display("FAIL %s_early got valid=%0b exp=0", tag, valid1);
        end
        tick();
        checks++;
        if (valid1 !== 1'b1 || idx1 !== 7'd3 || data1 !== 32'h103 || rs1 !== '0) begin
            failures++;
            $display("FAIL %s_first got v=%0b i=%0d d=%0h rs=%0h exp v=1 i=3 d=103 rs=0",
                     tag, valid1, idx1, data1, rs1);
        end
        tick();
        tick();
        tick();
        checks++;
        if (valid1 !== 1'b0) begin
            failures++;
            $display("FAIL %s_gap got valid=%0b exp=0", tag, valid1);
        end
        tick();
        checks++;
        if (valid1 !== 1'b1 || idx1 !== 7'd7 || data1 !== 32'h107 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL %s_second got v=%0b i=%0d d=%0h dn=%0b exp v=1 i=7 d=107 dn=0",
                     tag, valid1, idx1, data1, done1);
        end
        tick();
        checks++;
        if (valid1 !== 1'b0 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL %s_xfer2 got v=%0b dn=%0b exp v=0 dn=0", tag, valid1, done1);
        end
        tick();
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL %s_done got dn=%0b b=%0b exp dn=1 b=0", tag, done1, busy1);
        end
`ifdef CAPP_MATCH_COUNT_EN
        checks++;
        if (mc1 !== 8'd2) begin
            failures++;
            $display("FAIL %s_mcount got=%0d exp=2", tag, mc1);
        end
`endif
        tick();
        checks++;
        if (done1 !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_pulse got=%0b exp=0", tag, done1);
        end
        tags1 = '0;
    endtask

    task automatic test_empty();
        logic seen;
        seen = 1'b0;
        tags1 = '0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        seen = seen | valid1 | (|rs1);
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL empty_busy got b=%0b dn=%0b exp b=1 dn=0", busy1, done1);
        end
        tick();
        seen = seen | valid1 | (|rs1);
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b1) begin
            failures++;
            $display("FAIL empty_done got b=%0b dn=%0b exp b=0 dn=1", busy1, done1);
        end
        tick();
        seen = seen | valid1 | (|rs1);
        checks++;
        if (seen !== 1'b0 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL empty_quiet got activity=%0b dn=%0b exp 0 0", seen, done1);
        end
    endtask

    task automatic test_backpressure();
        int xfers;
        xfers = 0;
        tags1 = '0;
        tags1[5] = 1'b1;
        ready1 = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        tick();
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (valid1 !== 1'b1 || idx1 !== 7'd5 || data1 !== 32'h105) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%0b i=%0d d=%0h exp v=1 i=5 d=105",
                         c, valid1, idx1, data1);
            end
            tick();
        end
        ready1 = 1'b1;
        if (valid1) xfers++;
        tick();
        if (valid1) xfers++;
        checks++;
        if (valid1 !== 1'b0 || done1 !== 1'b0 || xfers !== 1) begin
            failures++;
            $display("FAIL bp_xfer got v=%0b dn=%0b xfers=%0d exp 0 0 1", valid1, done1, xfers);
        end
        tick();
        checks++;
        if (done1 !== 1'b1 || valid1 !== 1'b0) begin
            failures++;
            $display("FAIL bp_done got dn=%0b v=%0b exp dn=1 v=0", done1, valid1);
        end
        tick();
    endtask

    task automatic test_abort();
        logic dn_seen;
        dn_seen = 1'b0;
        tags1 = '0;
        tags1[2] = 1'b1;
        tags1[9] = 1'b1;
        ready1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || valid1 !== 1'b0 || rs1 !== '0) begin
            failures++;
            $display("FAIL abort_idle got b=%0b v=%0b rs=%0h exp 0 0 0", busy1, valid1, rs1);
        end
`ifdef CAPP_MATCH_COUNT_EN
        checks++;
        if (mc1 !== 8'd0) begin
            failures++;
            $display("FAIL abort_mcount got=%0d exp=0", mc1);
        end
`endif
        for (int c = 0; c < 4; c++) begin
            dn_seen = dn_seen | done1 | valid1;
            tick();
        end
        checks++;
        if (dn_seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_nodone got=%0b exp=0", dn_seen);
        end
        tags1 = '0;
        tags1[9] = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (valid1 !== 1'b1 || idx1 !== 7'd9 || data1 !== 32'h109) begin
            failures++;
            $display("FAIL abort_restart got v=%0b i=%0d d=%0h exp v=1 i=9 d=109",
                     valid1, idx1, data1);
        end
        tick();
        tick();
        checks++;
        if (done1 !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart_done got=%0b exp=1", done1);
        end
        tick();
    endtask

    task automatic test_boundary();
        logic seen50;
        int nvalid;
        seen50 = 1'b0;
        nvalid = 0;
        tags3 = '0;
        tags3[0] = 1'b1;
        tags3[N-1] = 1'b1;
        ready3 = 1'b1;
        start3 = 1'b1;
        tick();
        tags3 = '0;
        tags3[50] = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            start3 = (cyc == 2 || cyc == 7);
            tick();
            seen50 = seen50 | rs3[50] | (valid3 && idx3 == 7'd50);
            if (valid3) nvalid++;
            if (cyc == 4 || cyc == 10) begin
                checks++;
                if (valid3 !== 1'b0) begin
                    failures++;
                    $display("FAIL bnd_early%0d got valid=%0b exp=0", cyc, valid3);
                end
            end
            if (cyc == 5) begin
                checks++;
                if (valid3 !== 1'b1 || idx3 !== 7'd0 || data3 !== 32'h100) begin
                    failures++;
                    $display("FAIL bnd_bit0 got v=%0b i=%0d d=%0h exp v=1 i=0 d=100",
                             valid3, idx3, data3);
                end
            end
            if (cyc == 11) begin
                checks++;
                if (valid3 !== 1'b1 || idx3 !== 7'd99 || data3 !== 32'h163) begin
                    failures++;
                    $display("FAIL bnd_bit99 got v=%0b i=%0d d=%0h exp v=1 i=99 d=163",
                             valid3, idx3, data3);
                end
            end
            if (cyc == 13) begin
                checks++;
                if (done3 !== 1'b1) begin
                    failures++;
                    $display("FAIL bnd_done got=%0b exp=1", done3);
                end
            end
        end
        start3 = 1'b0;
        checks++;
        if (seen50 !== 1'b0 || nvalid !== 2) begin
            failures++;
            $display("FAIL bnd_only2 got row50=%0b results=%0d exp 0 2", seen50, nvalid);
        end
    endtask

    task automatic test_reset_mid_present();
        logic dn_seen;
        tags1 = '0;
        tags1[4] = 1'b1;
        ready1 = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (valid1 !== 1'b1 || idx1 !== 7'd4) begin
            failures++;
            $display("FAIL rstmid_pre got v=%0b i=%0d exp v=1 i=4", valid1, idx1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({rs1, valid1, idx1, data1, busy1, done1} !== '0) begin
            failures++;
            $display("FAIL rstmid_clear got rs=%0h v=%0b i=%0d d=%0h b=%0b dn=%0b exp all 0",
                     rs1, valid1, idx1, data1, busy1, done1);
        end
        dn_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            dn_seen = dn_seen | done1 | busy1;
        end
        checks++;
        if (dn_seen !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_nodone got=%0b exp=0", dn_seen);
        end
        test_ordered("rstmid_t1");
    endtask

    initial begin
        test_reset();
        test_ordered("ordered");
        test_empty();
        test_backpressure();
        test_abort();
        test_boundary();
        test_reset_mid_present();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
